// File: rtl/udp_csum_arb_pkg.sv
// Shared types and widths for the UDP checksum engine arbiter.
package udp_csum_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam int CSUM_W = 16;
  localparam int CNT_W  = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request above 'last' (with wrap) wins.
module rr_arbiter
  import udp_csum_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic found;

  // Walk the N positions after 'last'; 'last' itself is checked last so a
  // lone requester can still win back-to-back.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found                      = 1'b1;
        gnt[(int'(last) + k) % N]  = 1'b1;
        idx                        = IDX_W'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/udp_csum_arbiter.sv
// Shares one udp_checksum engine between N_REQ AXIS sources, round-robin per packet.
// Define UDP_CSUM_ARB_STATS_EN to build the per-requester completed-packet counters.
module udp_csum_arbiter
  import udp_csum_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    sresetn,
  input  logic [N_REQ-1:0]        req_tvalid,
  output logic [N_REQ-1:0]        req_tready,
  input  logic [N_REQ-1:0]        req_tlast,
  input  logic [CSUM_W*N_REQ-1:0] req_tdata,
  output logic                    eng_i_tvalid,
  output logic                    eng_i_tlast,
  output logic [CSUM_W-1:0]       eng_i_tdata,
  input  logic                    eng_i_tready,
  input  logic                    eng_o_tvalid,
  input  logic [CSUM_W-1:0]       eng_o_tdata,
  output logic                    eng_o_tready,
  output logic                    res_tvalid,
  input  logic                    res_tready,
  output logic [CSUM_W-1:0]       res_tdata,
  output logic [ID_W-1:0]         res_tid,
  output logic [CNT_W*N_REQ-1:0]  pkt_count
);

  arb_state_t       st_q, st_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req  (req_tvalid),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign arb_any = |arb_gnt;

  // last_q starts at N_REQ-1 so the first grant after reset lands on requester 0.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      st_q    <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Outputs are gated by sresetn so nothing leaks out while reset is held,
  // even before the first clock edge has cleared the state register.
  always_comb begin
    st_d         = st_q;
    grant_d      = grant_q;
    last_d       = last_q;
    req_tready   = '0;
    eng_i_tvalid = 1'b0;
    eng_i_tlast  = 1'b0;
    eng_i_tdata  = '0;
    eng_o_tready = 1'b0;
    res_tvalid   = 1'b0;
    res_tdata    = '0;
    res_tid      = '0;
    if (sresetn) begin
      case (st_q)
        IDLE: begin
          if (arb_any) begin
            grant_d = arb_idx;
            last_d  = arb_idx;
            st_d    = FWD;
          end
        end
        FWD: begin
          eng_i_tvalid        = req_tvalid[grant_q];
          eng_i_tlast         = req_tlast[grant_q];
          eng_i_tdata         = req_tdata[int'(grant_q)*CSUM_W +: CSUM_W];
          req_tready[grant_q] = eng_i_tready;
          if (req_tvalid[grant_q] && eng_i_tready && req_tlast[grant_q]) begin
            st_d = WAIT;
          end
        end
        WAIT: begin
          res_tvalid   = eng_o_tvalid;
          res_tdata    = eng_o_tdata;
          res_tid      = grant_q;
          eng_o_tready = res_tready;
          if (eng_o_tvalid && res_tready) begin
            st_d = IDLE;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

`ifdef UDP_CSUM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (res_tvalid && res_tready) begin
      cnt_q[res_tid] <= cnt_q[res_tid] + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
    assign pkt_count[CNT_W*gi +: CNT_W] = cnt_q[gi];
  end
`else
  assign pkt_count = '0;
`endif

endmodule
